// File: rtl/regfile_cmd_ctrl.sv
// Command initiator for the configuration register file: parses write/read
// frames from the serial front end, strobes the register file, returns a response byte.
//
// state     | meaning
// IDLE      | waiting for an opcode byte
// GET_ADDR  | waiting for the address byte
// GET_DATA  | waiting for the write data byte
// CHECK     | address range check
// DO_WRITE  | write strobe to the register file
// DO_READ   | read strobe to the register file
// READ_WAIT | capture registered readback
// SEND      | response byte offered until accepted
module regfile_cmd_ctrl #(
  parameter int         NUMREGS  = 16,
  parameter int         TIMEOUT  = 1024,
  parameter logic [7:0] ACK_BYTE = 8'hA5,
  parameter logic [7:0] NAK_BYTE = 8'h5A
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] write_addr,
  output logic [7:0] write_data,
  output logic       write,
  output logic [7:0] read_addr,
  output logic       read,
  input  logic [7:0] read_data,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_ADDR  = 3'd1;
  localparam logic [2:0] S_GET_DATA  = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_DO_WRITE  = 3'd4;
  localparam logic [2:0] S_DO_READ   = 3'd5;
  localparam logic [2:0] S_READ_WAIT = 3'd6;
  localparam logic [2:0] S_SEND      = 3'd7;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam int unsigned NUMREGS_U = NUMREGS;
  localparam int          CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic             is_write;
  logic [7:0]       addr_q;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] timer;
  logic             addr_ok;
  logic             timed_out;
  logic             opcode_ok;
  logic             err_inc;

  assign addr_ok   = ({24'd0, addr_q} < NUMREGS_U);
  assign timed_out = !rx_valid && (timer == CNT_LAST);
  assign opcode_ok = (rx_data == OP_WRITE) || (rx_data == OP_READ);

  assign write    = (state == S_DO_WRITE);
  assign read     = (state == S_DO_READ);
  assign tx_valid = (state == S_SEND);
  assign busy     = (state != S_IDLE);

  // All error sources of one cycle collapse into a single increment.
  always_comb begin
    err_inc = 1'b0;
    unique case (state)
      S_IDLE:                 err_inc = rx_valid && !opcode_ok;
      S_GET_ADDR, S_GET_DATA: err_inc = timed_out;
      S_CHECK:                err_inc = rx_valid || !addr_ok;
      default:                err_inc = rx_valid;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= 8'h00;
    end else if (err_inc && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      is_write   <= 1'b0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      timer      <= '0;
      tx_data    <= 8'h00;
      write_addr <= 8'h00;
      write_data <= 8'h00;
      read_addr  <= 8'h00;
    end else begin
      timer <= '0;
      unique case (state)
        S_IDLE: begin
          if (rx_valid && opcode_ok) begin
            is_write <= (rx_data == OP_WRITE);
            state    <= S_GET_ADDR;
          end
        end
        S_GET_ADDR: begin
          if (rx_valid) begin
            addr_q <= rx_data;
            state  <= is_write ? S_GET_DATA : S_CHECK;
          end else if (timed_out) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GET_DATA: begin
          if (rx_valid) begin
            data_q <= rx_data;
            state  <= S_CHECK;
          end else if (timed_out) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CHECK: begin
          if (!addr_ok) begin
            tx_data <= NAK_BYTE;
            state   <= S_SEND;
          end else if (is_write) begin
            write_addr <= addr_q;
            write_data <= data_q;
            state      <= S_DO_WRITE;
          end else begin
            read_addr <= addr_q;
            state     <= S_DO_READ;
          end
        end
        S_DO_WRITE: begin
          tx_data <= ACK_BYTE;
          state   <= S_SEND;
        end
        S_DO_READ: begin
          state <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          tx_data <= read_data;
          state   <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a small register file model that
// returns registered readback the cycle after the read strobe.
module tb_regfile_cmd_ctrl;

  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic       write;
  logic [7:0] read_addr;
  logic       read;
  logic [7:0] read_data;
  logic       busy;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  int rd_count = 0;
  int both_count = 0;
  int w0;
  int r0;

  logic [7:0] mem [16];

  regfile_cmd_ctrl #(
    .NUMREGS(16), .TIMEOUT(TIMEOUT), .ACK_BYTE(8'hA5), .NAK_BYTE(8'h5A)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .write_addr(write_addr), .write_data(write_data), .write(write),
    .read_addr(read_addr), .read(read), .read_data(read_data),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Register file model; unwritten registers read back as 8'h30 + index.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h30 + 8'(i);
      read_data <= 8'h00;
    end else begin
      if (write) mem[write_addr[3:0]] <= write_data;
      if (read) read_data <= mem[read_addr[3:0]];
    end
  end

  always @(posedge clk) begin
    if (write) wr_count++;
    if (read) rd_count++;
    if (write && read) both_count++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    n_cmp++; if ({tx_valid, write, read, busy} !== 4'b0000) begin n_bad++; $display("FAIL reset_strobes: got %b want 0000", {tx_valid, write, read, busy}); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if ({write_addr, write_data, read_addr} !== 24'h0) begin n_bad++; $display("FAIL reset_addr_data: got %h want 000000", {write_addr, write_data, read_addr}); end
    n_cmp++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL reset_err: got %h want 00", err_count); end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_write();
    do_reset();
    w0 = wr_count;
    tx_ready = 1'b0;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hC4);
    n_cmp++; if ({write, busy} !== 2'b01) begin n_bad++; $display("FAIL wr_n1: got %b want 01", {write, busy}); end
    tick(1);
    n_cmp++; if ({write, read, write_addr, write_data} !== 18'b10_00000011_11000100) begin n_bad++; $display("FAIL wr_strobe: got w=%b r=%b a=%h d=%h want w=1 r=0 a=03 d=C4", write, read, write_addr, write_data); end
    tick(1);
    n_cmp++; if ({write, tx_valid, tx_data} !== 10'b01_10100101) begin n_bad++; $display("FAIL wr_ack: got w=%b v=%b d=%h want w=0 v=1 d=A5", write, tx_valid, tx_data); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_cmp++; if ({tx_valid, tx_data} !== 9'h1A5) begin n_bad++; $display("FAIL wr_hold%0d: got v=%b d=%h want v=1 d=A5", i, tx_valid, tx_data); end
    end
    tx_ready = 1'b1;
    tick(1);
    n_cmp++; if ({tx_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL wr_done: got %b want 00", {tx_valid, busy}); end
    n_cmp++; if (wr_count - w0 !== 1) begin n_bad++; $display("FAIL wr_count: got %0d want 1", wr_count - w0); end
    n_cmp++; if (mem[3] !== 8'hC4) begin n_bad++; $display("FAIL wr_mem: got %h want C4", mem[3]); end
  endtask

  task automatic test_read();
    r0 = rd_count;
    send_byte(8'h52); send_byte(8'h03);
    n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL rd_n1: got %b want 0", read); end
    tick(1);
    n_cmp++; if ({read, write, read_addr} !== 10'b10_00000011) begin n_bad++; $display("FAIL rd_strobe: got r=%b w=%b a=%h want r=1 w=0 a=03", read, write, read_addr); end
    tick(1);
    n_cmp++; if ({read, tx_valid} !== 2'b00) begin n_bad++; $display("FAIL rd_n3: got %b want 00", {read, tx_valid}); end
    tick(1);
    n_cmp++; if ({tx_valid, tx_data} !== 9'h1C4) begin n_bad++; $display("FAIL rd_data: got v=%b d=%h want v=1 d=C4", tx_valid, tx_data); end
    tick(1);
    n_cmp++; if ({tx_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rd_idle: got %b want 00", {tx_valid, busy}); end
    n_cmp++; if (rd_count - r0 !== 1) begin n_bad++; $display("FAIL rd_count: got %0d want 1", rd_count - r0); end
  endtask

  task automatic test_nak();
    do_reset();
    w0 = wr_count;
    r0 = rd_count;
    send_byte(8'h57); send_byte(8'h20); send_byte(8'h11);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL nak_n1: got %b want 0", tx_valid); end
    tick(1);
    n_cmp++; if ({tx_valid, tx_data, err_count} !== 17'h15A01) begin n_bad++; $display("FAIL nak_resp: got v=%b d=%h e=%h want v=1 d=5A e=01", tx_valid, tx_data, err_count); end
    tick(1);
    n_cmp++; if ((wr_count - w0 !== 0) || busy !== 1'b0) begin n_bad++; $display("FAIL nak_nowrite: got writes=%0d busy=%b want 0 0", wr_count - w0, busy); end
    send_byte(8'h13);
    n_cmp++; if ({err_count, tx_valid, busy} !== 10'b00000010_00) begin n_bad++; $display("FAIL bad_opcode: got e=%h v=%b b=%b want e=02 v=0 b=0", err_count, tx_valid, busy); end
    tick(3);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL bad_opcode_noresp: got %b want 0", tx_valid); end
    send_byte(8'h52); send_byte(8'h10);
    tick(1);
    n_cmp++; if ({tx_valid, tx_data, err_count} !== 17'h15A03) begin n_bad++; $display("FAIL nak_addr16: got v=%b d=%h e=%h want v=1 d=5A e=03", tx_valid, tx_data, err_count); end
    tick(1);
    send_byte(8'h52); send_byte(8'h0F);
    tick(3);
    n_cmp++; if ({tx_valid, tx_data, err_count} !== 17'h13F03) begin n_bad++; $display("FAIL rd_addr15: got v=%b d=%h e=%h want v=1 d=3F e=03", tx_valid, tx_data, err_count); end
    tick(1);
    n_cmp++; if (rd_count - r0 !== 1) begin n_bad++; $display("FAIL nak_noread: got %0d want 1", rd_count - r0); end
  endtask

  task automatic test_timeout();
    do_reset();
    w0 = wr_count;
    send_byte(8'h57); send_byte(8'h05);
    tick(10);
    n_cmp++; if ({busy, err_count} !== 9'h100) begin n_bad++; $display("FAIL to_waiting: got b=%b e=%h want b=1 e=00", busy, err_count); end
    tick(TIMEOUT);
    n_cmp++; if ({busy, tx_valid, err_count} !== 10'b00_00000001) begin n_bad++; $display("FAIL to_abort: got b=%b v=%b e=%h want b=0 v=0 e=01", busy, tx_valid, err_count); end
    n_cmp++; if (wr_count - w0 !== 0) begin n_bad++; $display("FAIL to_nowrite: got %0d want 0", wr_count - w0); end
    send_byte(8'h52); send_byte(8'h05);
    tick(3);
    n_cmp++; if ({tx_valid, tx_data, err_count} !== 17'h13501) begin n_bad++; $display("FAIL to_next_frame: got v=%b d=%h e=%h want v=1 d=35 e=01", tx_valid, tx_data, err_count); end
    tick(1);
  endtask

  task automatic test_overrun();
    do_reset();
    send_byte(8'h52); send_byte(8'h01);
    tick(1);
    n_cmp++; if ({read, read_addr} !== 9'h101) begin n_bad++; $display("FAIL ov_read: got r=%b a=%h want r=1 a=01", read, read_addr); end
    tick(1);
    send_byte(8'h57);
    n_cmp++; if ({tx_valid, tx_data, err_count} !== 17'h13101) begin n_bad++; $display("FAIL ov_resp: got v=%b d=%h e=%h want v=1 d=31 e=01", tx_valid, tx_data, err_count); end
    tick(4);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ov_dropped: got busy=%b want 0", busy); end
    for (int i = 0; i < 253; i++) send_byte(8'h13);
    n_cmp++; if (err_count !== 8'hFE) begin n_bad++; $display("FAIL err_fe: got %h want FE", err_count); end
    for (int i = 0; i < 47; i++) send_byte(8'h13);
    n_cmp++; if ({err_count, tx_valid, busy} !== 10'b11111111_00) begin n_bad++; $display("FAIL err_sat: got e=%h v=%b b=%b want e=FF v=0 b=0", err_count, tx_valid, busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    w0 = wr_count;
    send_byte(8'h57); send_byte(8'h02);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({busy, write, tx_valid, err_count} !== 11'h0) begin n_bad++; $display("FAIL rm_async: got b=%b w=%b v=%b e=%h want all 0", busy, write, tx_valid, err_count); end
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    n_cmp++; if (wr_count - w0 !== 0) begin n_bad++; $display("FAIL rm_nowrite: got %0d want 0", wr_count - w0); end
    send_byte(8'h57); send_byte(8'h02); send_byte(8'h7E);
    tick(1);
    n_cmp++; if ({write, write_addr, write_data} !== 17'h1027E) begin n_bad++; $display("FAIL rm_write: got w=%b a=%h d=%h want w=1 a=02 d=7E", write, write_addr, write_data); end
    tick(1);
    n_cmp++; if ({tx_valid, tx_data} !== 9'h1A5) begin n_bad++; $display("FAIL rm_ack: got v=%b d=%h want v=1 d=A5", tx_valid, tx_data); end
    tick(1);
    n_cmp++; if (mem[2] !== 8'h7E) begin n_bad++; $display("FAIL rm_mem: got %h want 7E", mem[2]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_timeout();
    test_overrun();
    test_reset_mid();
    n_cmp++; if (both_count !== 0) begin n_bad++; $display("FAIL strobe_excl: got %0d cycles with both want 0", both_count); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_cmd_ctrl.md
Name: regfile_cmd_ctrl

Overview:
- Command initiator for the configuration register file.
- Takes a received byte stream (from the UART/SPI deserialiser), parses write/read frames, and drives the register file write/read ports for one cycle.
- Returns an ACK, NAK or readback byte on a transmit handshake.
- Sits between the serial front end and the register file inside digital_core.

Parameters:
NUMREGS, 16, number of implemented registers; addresses >= NUMREGS are rejected
TIMEOUT, 1024, idle cycles allowed between bytes of one frame before abort (>=2)
ACK_BYTE, 8'hA5, response to a successful write
NAK_BYTE, 8'h5A, response to a rejected frame (bad address)

Ports:
clk  input  1  system clock
reset_n  input  1  digital reset, asynchronous, active low
rx_data  input  8  received byte, valid while rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte; no backpressure
tx_data  output  8  response byte
tx_valid  output  1  response valid; held until tx_ready
tx_ready  input  1  serialiser accepts tx_data when tx_valid & tx_ready
write_addr  output  8  register file write address
write_data  output  8  register file write data
write  output  1  one-cycle write strobe
read_addr  output  8  register file read address
read  output  1  one-cycle read strobe
read_data  input  8  register file readback, registered, valid the cycle after read
busy  output  1  high in any state other than IDLE
err_count  output  8  saturating count of protocol errors

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active low.
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset mid-frame discards the frame, and no write/read strobe is issued.
- Frame format:
  - write: 8'h57, addr, data
  - read: 8'h52, addr
- States: IDLE, GET_ADDR, GET_DATA, CHECK, DO_WRITE, DO_READ, READ_WAIT, SEND.
- IDLE:
  - rx_valid with 8'h57 or 8'h52: latch the opcode, go to GET_ADDR.
  - Any other byte: err_count++, stay in IDLE, no response.
- GET_ADDR: rx_valid latches addr.
  - Write opcode: go to GET_DATA.
  - Read opcode: go to CHECK.
- GET_DATA: rx_valid latches data, go to CHECK.
- CHECK (1 cycle):
  - addr >= NUMREGS: tx_data <= NAK_BYTE, err_count++, go to SEND.
  - Otherwise: go to DO_WRITE or DO_READ.
- DO_WRITE (1 cycle):
  - write=1, write_addr=addr, write_data=data.
  - Next: tx_data <= ACK_BYTE, go to SEND.
- DO_READ (1 cycle): read=1, read_addr=addr, go to READ_WAIT.
- READ_WAIT (1 cycle): tx_data <= read_data, go to SEND.
- SEND:
  - tx_valid=1, tx_data held stable.
  - On tx_valid & tx_ready: tx_valid drops next cycle, go to IDLE.
  - Wait for tx_ready is unbounded.
- Latency (last frame byte accepted at cycle N):
  - write strobe at N+2; ACK tx_valid at N+3.
  - read strobe at N+2; readback tx_valid at N+4.
  - NAK tx_valid at N+2.
- Strobe timing: write and read are combinationally decoded from state only, never both high, each exactly one cycle per frame. write_addr/write_data/read_addr are registered and hold their last value outside the strobe.
- Timeout:
  - In GET_ADDR or GET_DATA, the counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT-1: err_count++, go to IDLE, no strobe, no response.
  - Counter is 0 in all other states.
- Overrun: rx_valid in CHECK, DO_WRITE, DO_READ, READ_WAIT or SEND drops the byte and increments err_count; the current frame continues unaffected.
- err_count saturates at 8'hFF and is cleared only by reset. Simultaneous error sources in one cycle count once.
- Address 8'hFF with NUMREGS=16 yields NAK. NUMREGS=256 accepts all addresses.

Test Plan:
- Reset, then rx 57,03,C4 -> one-cycle write with addr 03, data C4 at N+2; tx_data A5 at N+3. Hold tx_ready=0 for 5 cycles -> tx_valid stays 1, tx_data stable.
- After the write above, rx 52,03 -> read=1, read_addr 03 at N+2; model returns C4 next cycle; tx_valid with tx_data C4 at N+4; tx_ready=1 -> back to IDLE, busy=0.
- rx 57,20,11 with NUMREGS=16 -> no write strobe, tx_data 5A, err_count=1. rx 13 in IDLE -> err_count=2, no tx_valid.
- rx 57,05 then silence for TIMEOUT cycles -> return to IDLE, err_count=1, no strobe. Next frame 52,05 completes normally.
- rx 52,01 followed by an extra byte during READ_WAIT -> byte dropped, err_count=1, readback still sent. Then 300 bad opcodes -> err_count=FF.
- Assert reset_n low during GET_DATA of 57,02,xx -> outputs 0 immediately, no write issued. After release, frame 57,02,7E writes 7E.
